// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b register/opcode types and hazard FSM state encoding
package lc3b_types;
  typedef logic [2:0] lc3b_reg;
  typedef enum logic [3:0] {
    op_br   = 4'b0000, op_add  = 4'b0001, op_ldb = 4'b0010, op_stb = 4'b0011,
    op_jsr  = 4'b0100, op_and  = 4'b0101, op_ldr = 4'b0110, op_str = 4'b0111,
    op_rti  = 4'b1000, op_not  = 4'b1001, op_ldi = 4'b1010, op_sti = 4'b1011,
    op_jmp  = 4'b1100, op_shf  = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;
  typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, FLUSH = 2'd2} hazard_state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction
endpackage

// File: rtl/hazard_controller_detect.sv
// hazard_detect: combinational load-use hazard detection between ID and EX
// Ports: id_opcode/id_sr1/id_sr2/id_sr2_used describe the ID instruction;
//        ex_memread/ex_regwrite/ex_destreg describe the EX instruction;
//        lu_hazard is high when ID reads a register the EX load will write.
module hazard_detect
  import lc3b_types::*;
(
  input  lc3b_opcode id_opcode,
  input  lc3b_reg    id_sr1,
  input  lc3b_reg    id_sr2,
  input  logic       id_sr2_used,
  input  logic       ex_memread,
  input  logic       ex_regwrite,
  input  lc3b_reg    ex_destreg,
  output logic       lu_hazard
);
  logic sr1_used;
  // BR, LEA and TRAP carry no sr1 field; their bits [8:6] are not a register
  assign sr1_used = !(id_opcode inside {op_br, op_lea, op_trap});
  assign lu_hazard = ex_memread & ex_regwrite &
                     ((sr1_used & (ex_destreg == id_sr1)) | (id_sr2_used & (ex_destreg == id_sr2)));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush/bubble control for the LC-3b pipeline
// Ports: clk, rst_n (async active-low); ID/EX operand info for load-use detection;
//        imem/dmem request+response for memory stalls; mem_branch_taken from MEM;
//        load_* pipeline-register enables, flush_* NOP injects, bubble_id_ex.
// Optional: define HAZARD_PERF_EN to add saturating stall_cycles, bubble_count
//           and flush_count outputs.
module hazard_controller
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  lc3b_opcode  id_opcode,
  input  lc3b_reg     id_sr1,
  input  lc3b_reg     id_sr2,
  input  logic        id_sr2_used,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  lc3b_reg     ex_destreg,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        mem_branch_taken,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
`ifdef HAZARD_PERF_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] bubble_count,
  output logic [15:0] flush_count,
`endif
  output logic        bubble_id_ex
);
  hazard_state_t state_q, state_d;
  logic lu_hazard, mem_stall, bubble_evt, flush_evt;

  hazard_detect u_detect (
    .id_opcode  (id_opcode),
    .id_sr1     (id_sr1),
    .id_sr2     (id_sr2),
    .id_sr2_used(id_sr2_used),
    .ex_memread (ex_memread),
    .ex_regwrite(ex_regwrite),
    .ex_destreg (ex_destreg),
    .lu_hazard  (lu_hazard)
  );

  // A response in the same cycle as its request releases the stall immediately
  assign mem_stall = (imem_read & !imem_resp) | (dmem_req & !dmem_resp);
  assign flush_evt = !mem_stall & mem_branch_taken;
  assign bubble_evt = !mem_stall & !mem_branch_taken & (state_q == RUN) & lu_hazard;

  always_comb begin
    state_d = state_q;
    {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
    {flush_if_id, flush_id_ex, flush_ex_mem, bubble_id_ex} = 4'b0000;
    if (mem_stall) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b00000;
    end else if (mem_branch_taken) begin
      {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
      state_d = FLUSH;
    end else if (state_q == FLUSH) begin
      // The fetch issued in the flush cycle came from the stale PC
      flush_if_id = 1'b1;
      state_d = RUN;
    end else if (state_q == LU_STALL) begin
      state_d = RUN;
    end else if (lu_hazard) begin
      {load_pc, load_if_id} = 2'b00;
      bubble_id_ex = 1'b1;
      state_d = LU_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d, bubble_count_q, bubble_count_d, flush_count_q, flush_count_d;
  always_comb begin
    stall_cycles_d = sat_inc(stall_cycles_q, mem_stall);
    bubble_count_d = sat_inc(bubble_count_q, bubble_evt);
    flush_count_d = sat_inc(flush_count_q, flush_evt);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign bubble_count = bubble_count_q;
  assign flush_count = flush_count_q;
`else
  logic unused_evt;
  assign unused_evt = bubble_evt ^ flush_evt;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven self-checking bench for hazard_controller
module tb_hazard_controller;
  import lc3b_types::*;
  logic clk = 1'b0, rst_n = 1'b0;
  lc3b_opcode id_opcode = op_add;
  lc3b_reg id_sr1 = '0, id_sr2 = '0, ex_destreg = '0;
  logic id_sr2_used = 0, ex_memread = 0, ex_regwrite = 0;
  logic imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0, mem_branch_taken = 0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, bubble_id_ex;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, bubble_count, flush_count;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_sr2_used(id_sr2_used), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_destreg(ex_destreg), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .mem_branch_taken(mem_branch_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count),
`endif
    .bubble_id_ex(bubble_id_ex)
  );

  logic [8:0] outs;
  assign outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                 flush_if_id, flush_id_ex, flush_ex_mem, bubble_id_ex};

  localparam logic [8:0] ALL = 9'b11111_000_0, STL = 9'b00000_000_0, BUB = 9'b00111_000_1;
  localparam logic [8:0] BRF = 9'b11111_111_0, FLS = 9'b11111_100_0;

  typedef struct {
    lc3b_opcode op;
    lc3b_reg sr1, sr2, dst;
    logic s2u, mr, rw, ir, irs, dr, drs, br;
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mk(lc3b_opcode op, lc3b_reg sr1, lc3b_reg sr2, logic s2u,
                              logic mr, logic rw, lc3b_reg dst, logic ir, logic irs,
                              logic dr, logic drs, logic br, logic [8:0] exp);
    vec_t v;
    v.op = op; v.sr1 = sr1; v.sr2 = sr2; v.s2u = s2u; v.mr = mr; v.rw = rw; v.dst = dst;
    v.ir = ir; v.irs = irs; v.dr = dr; v.drs = drs; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_opcode = v.op; id_sr1 = v.sr1; id_sr2 = v.sr2; id_sr2_used = v.s2u;
    ex_memread = v.mr; ex_regwrite = v.rw; ex_destreg = v.dst;
    imem_read = v.ir; imem_resp = v.irs; dmem_req = v.dr; dmem_resp = v.drs;
    mem_branch_taken = v.br;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  vec_t tbl[$];
  vec_t idle, haz;

  initial begin
    idle = mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, ALL);
    haz  = mk(op_add, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, BUB);
    tbl.push_back(idle);
    tbl.push_back(haz);
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(idle);
    tbl.push_back(mk(op_lea, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(mk(op_lea, 3'd3, 3'd3, 1, 1, 1, 3'd3, 0, 0, 0, 0, 0, BUB));
    tbl.push_back(idle);
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 1, 0, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 0, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(mk(op_add, 3'd2, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0, STL));
    tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 1, 0, ALL));
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 1, BRF));
    tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, FLS));
    tbl.push_back(idle);
    tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 1, STL));
    tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 1, STL));
    tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 1, 0, 0, 1, BRF));
    tbl.push_back(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, BRF));
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, FLS));
    tbl.push_back(haz);
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 1, 0, 0, STL));
    tbl.push_back(mk(op_add, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(idle);
    tbl.push_back(mk(op_br, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(mk(op_trap, 3'd3, 3'd0, 0, 1, 1, 3'd3, 0, 0, 0, 0, 0, ALL));
    tbl.push_back(mk(op_str, 3'd1, 3'd3, 1, 1, 1, 3'd3, 0, 0, 0, 0, 0, BUB));
    tbl.push_back(idle);

    drive(idle);
    #1 chk("reset_outputs", {7'd0, outs}, {7'd0, ALL});
`ifdef HAZARD_PERF_EN
    chk("reset_stall_cycles", stall_cycles, 16'd0);
    chk("reset_bubble_count", bubble_count, 16'd0);
    chk("reset_flush_count", flush_count, 16'd0);
`endif
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
`ifdef HAZARD_PERF_EN
      if (i == 16) chk("stall_cycles_after_dmem", stall_cycles, 16'd5);
`endif
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), {7'd0, outs}, {7'd0, tbl[i].exp});
      chk($sformatf("vec%0d_bub_vs_flush", i), {15'd0, bubble_id_ex & flush_id_ex}, 16'd0);
    end

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    drive(idle);
    #1;
    chk("stall_cycles_total", stall_cycles, 16'd8);
    chk("bubble_count_total", bubble_count, 16'd4);
    chk("flush_count_total", flush_count, 16'd3);
`endif

    @(negedge clk);
    drive(haz);
    #1 chk("pre_reset_bubble", {7'd0, outs}, {7'd0, BUB});
    @(negedge clk);
    #1 chk("in_lu_stall", {7'd0, outs}, {7'd0, ALL});
    #2 rst_n = 1'b0;
    #1 chk("async_reset_to_run", {7'd0, outs}, {7'd0, BUB});
`ifdef HAZARD_PERF_EN
    chk("async_reset_stall_cycles", stall_cycles, 16'd0);
    chk("async_reset_bubble_count", bubble_count, 16'd0);
    chk("async_reset_flush_count", flush_count, 16'd0);
`endif
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    #1 chk("release_no_bubble", {7'd0, outs}, {7'd0, ALL});
    @(negedge clk);
    #1 chk("release_run", {7'd0, outs}, {7'd0, ALL});

    drive(mk(op_add, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1, BRF));
    #1 chk("branch_before_reset", {7'd0, outs}, {7'd0, BRF});
    @(negedge clk);
    drive(idle);
    #1 chk("in_flush", {7'd0, outs}, {7'd0, FLS});
    rst_n = 1'b0;
    #1 chk("reset_abandons_flush", {7'd0, outs}, {7'd0, ALL});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("no_flush_after_release", {7'd0, outs}, {7'd0, ALL});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port id_opcode, input, lc3b_opcode: opcode of instruction in ID.
REQ-004 SHALL have ports id_sr1 and id_sr2, input, lc3b_reg: source registers in ID.
REQ-005 SHALL have port id_sr2_used, input, 1: ID instruction reads sr2 (register-mode ALU ops, STR/STB/STI).
REQ-006 SHALL have ports ex_memread and ex_regwrite, input, 1 each: EX instruction is a load and writes the register file.
REQ-007 SHALL have port ex_destreg, input, lc3b_reg: EX destination register.
REQ-008 SHALL have ports imem_read and imem_resp, input, 1 each: fetch request and completion.
REQ-009 SHALL have ports dmem_req and dmem_resp, input, 1 each: data access request (read or write) and completion.
REQ-010 SHALL have port mem_branch_taken, input, 1: taken control transfer (BR, JMP, JSR, TRAP) resolved in MEM.
REQ-011 SHALL have outputs load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, 1 each: pipeline-register enables.
REQ-012 SHALL have outputs flush_if_id, flush_id_ex, flush_ex_mem, 1 each: load NOP into the register instead of upstream data.
REQ-013 SHALL have output bubble_id_ex, 1: load NOP into ID/EX while IF/ID and PC hold.

Function
REQ-014 mem_stall SHALL equal (imem_read & !imem_resp) | (dmem_req & !dmem_resp), combinational.
REQ-015 lu_hazard SHALL equal ex_memread & ex_regwrite & ((sr1_used & ex_destreg==id_sr1) | (id_sr2_used & ex_destreg==id_sr2)); sr1_used is 0 only for op_br, op_lea, op_trap.
REQ-016 FSM states SHALL be RUN, LU_STALL, FLUSH; priority mem_stall > mem_branch_taken > lu_hazard.
REQ-017 mem_stall, any state: all load_* = 0, all flush_*/bubble = 0, state held; zero-cycle added latency on resp.
REQ-018 mem_branch_taken, no mem_stall, any state: all load_* = 1, flush_if_id = flush_id_ex = flush_ex_mem = 1; next state FLUSH.
REQ-019 FLUSH, no mem_stall: all load_* = 1, flush_if_id = 1 (discard fetch from stale PC), others 0; next RUN; a new mem_branch_taken in FLUSH re-applies REQ-018.
REQ-020 RUN, lu_hazard, no higher priority: load_pc = load_if_id = 0, load_id_ex = 1, bubble_id_ex = 1, load_ex_mem = load_mem_wb = 1; next LU_STALL.
REQ-021 LU_STALL, no higher priority: all load_* = 1, no flush/bubble, lu_hazard ignored (exactly one bubble per load); next RUN.
REQ-022 RUN, no event: all load_* = 1, flush/bubble = 0.
REQ-023 bubble_id_ex and flush_id_ex SHALL never both be 1 in a cycle.

Reset
REQ-024 rst_n low SHALL force state RUN immediately; outputs then follow RUN decoding, and HAZARD_PERF_EN counters = 0.
REQ-025 Reset mid-stall or mid-flush SHALL abandon the sequence; no bubble/flush pending after release.

Configuration
REQ-026 Macro HAZARD_PERF_EN defined: outputs stall_cycles, bubble_count, flush_count, 16 bits each, saturating at 16'hFFFF, counting mem_stall cycles, REQ-020 entries, REQ-018 entries.
REQ-027 HAZARD_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 lc3b_types SHALL hold the hazard_state_t enum (RUN, LU_STALL, FLUSH); lc3b_reg and lc3b_opcode reused.
REQ-029 Combinational sub-module hazard_detect SHALL compute lu_hazard (REQ-015); FSM and counters in hazard_controller.

Verification
REQ-030 ex_memread=1, ex_regwrite=1, ex_destreg=3, id_opcode=op_add, id_sr1=3 -> one cycle load_pc=0, bubble_id_ex=1; next cycle all loads 1.
REQ-031 Same as REQ-030 but id_opcode=op_lea -> no bubble; with id_sr2_used=1, id_sr2=3 -> bubble.
REQ-032 dmem_req=1, dmem_resp=0 for 5 cycles, then resp=1 -> 5 cycles all loads 0, loads 1 on resp cycle; stall_cycles=5 with HAZARD_PERF_EN.
REQ-033 mem_branch_taken=1 coincident with lu_hazard -> three flushes, no bubble; next cycle flush_if_id only; then RUN.
REQ-034 mem_branch_taken=1 with imem_read=1, imem_resp=0 -> all loads 0, no flush until imem_resp=1, then REQ-018.
REQ-035 rst_n low during LU_STALL -> state RUN asynchronously; counters 0; no bubble after release.
